// File: rtl/ee354_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ee354_debouncer_pkg
// Brief    : State codes and default timing constants for the button debouncer.
// Revision : 1.0 - initial release
// ============================================================================
package ee354_debouncer_pkg;

    localparam logic [2:0] ST_INI  = 3'd0;
    localparam logic [2:0] ST_WQ   = 3'd1;
    localparam logic [2:0] ST_SCEN = 3'd2;
    localparam logic [2:0] ST_CCR  = 3'd3;
    localparam logic [2:0] ST_MCEN = 3'd4;
    localparam logic [2:0] ST_WFCR = 3'd5;

    // Board values at 100 MHz: 25 ms debounce, 0.5 s auto-repeat
    localparam int unsigned DEF_CNT_W       = 28;
    localparam int unsigned DEF_DEB_CYCLES  = 2500000;
    localparam int unsigned DEF_HOLD_CYCLES = 50000000;

endpackage
`default_nettype wire

// File: rtl/ee354_sync2.sv
`default_nettype none
// ============================================================================
// Module   : ee354_sync2
// Brief    : Two-flop synchronizer with synchronous active-low clear.
// Revision : 1.0 - initial release
// ============================================================================
module ee354_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule
`default_nettype wire

// File: rtl/ee354_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : ee354_debouncer
// Brief    : Push-button debouncer producing a clean level plus single,
//            auto-repeat and continuous clock-enable pulses.
// Revision : 1.0 - initial release
// ============================================================================
module ee354_debouncer
    import ee354_debouncer_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       PB,
    output logic       DPB,
    output logic       SCEN,
    output logic       MCEN,
    output logic       CCEN,
    output logic [2:0] state_out
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             pb_s;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dpb_q, dpb_d;
    logic             scen_q, scen_d;
    logic             mcen_q, mcen_d;
    logic             ccen_q, ccen_d;

    ee354_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (PB),
        .o_q   (pb_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INI: begin
                if (pb_s) begin
                    state_d = ST_WQ;
                    cnt_d   = '0;
                end
            end
            ST_WQ: begin
                if (!pb_s)                 state_d = ST_INI;
                else if (cnt_q == DEB_LAST) state_d = ST_SCEN;
                else                        cnt_d   = cnt_q + CNT_ONE;
            end
            ST_SCEN, ST_MCEN: begin
                state_d = ST_CCR;
                cnt_d   = '0;
            end
            ST_CCR: begin
                if (!pb_s) begin
                    state_d = ST_WFCR;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_MCEN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WFCR: begin
                // A high sample during release is a bounce: restart the count
                if (pb_s)                   cnt_d   = '0;
                else if (cnt_q == DEB_LAST) state_d = ST_INI;
                else                        cnt_d   = cnt_q + CNT_ONE;
            end
            default: begin
                state_d = ST_INI;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies track state_q
    always_comb begin
        dpb_d  = (state_d == ST_SCEN) || (state_d == ST_CCR) ||
                 (state_d == ST_MCEN) || (state_d == ST_WFCR);
        scen_d = (state_d == ST_SCEN);
        mcen_d = (state_d == ST_SCEN) || (state_d == ST_MCEN);
        ccen_d = (state_d == ST_SCEN) || (state_d == ST_CCR) || (state_d == ST_MCEN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_INI;
            cnt_q   <= '0;
            dpb_q   <= 1'b0;
            scen_q  <= 1'b0;
            mcen_q  <= 1'b0;
            ccen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dpb_q   <= dpb_d;
            scen_q  <= scen_d;
            mcen_q  <= mcen_d;
            ccen_q  <= ccen_d;
        end
    end

    assign DPB       = dpb_q;
    assign SCEN      = scen_q;
    assign MCEN      = mcen_q;
    assign CCEN      = ccen_q;
    assign state_out = state_q;

endmodule
`default_nettype wire
